mac_sequencer: RTL and testbench

Job controller that drives one signed multiply-accumulate unit (clear/compute/a/b in, acc out) to compute a length-K dot product.
- Accepts a start command with a length.
- Zeroes the MAC.
- Streams K operand pairs from an upstream valid/ready source into the MAC.
- Waits for the final accumulate to land, captures the accumulator, and presents it on a valid/ready result port.
- Sits between the operand/weight buffers and the MAC array in the CNN datapath.

---
 rtl/mac_sequencer.sv | 136 +++++++++++++
 tb/tb_mac_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// mac_sequencer
//   Job controller for a single signed multiply-accumulate unit. A start
//   command carries a length K. The sequencer zeroes the MAC, streams K operand
//   pairs from an upstream valid/ready source into it, and waits for the final
//   accumulate to land. It then captures the accumulator and offers it on a
//   valid/ready result port.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, length     job request and pair count, sampled only when idle
//   op_a, op_b        signed operand pair from upstream
//   op_valid/op_ready upstream operand handshake
//   mac_clear         zeroes the MAC accumulator
//   mac_compute       MAC adds mac_a*mac_b at the end of the cycle
//   mac_a, mac_b      registered operands to the MAC
//   mac_acc           MAC accumulator value
//   res_data          captured dot-product result
//   res_valid/ready   downstream result handshake
//   busy              high whenever a job is in progress
//   done              one-cycle pulse after the result handshake

module mac_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  op_valid,
  output logic                  op_ready,
  output logic                  mac_clear,
  output logic                  mac_compute,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  input  logic [ACC_WIDTH-1:0]  mac_acc,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_CAPTURE,
    S_OUTPUT
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 beat;

  // Next-state and Moore output decode. op_ready depends on state alone, so
  // upstream never sees a combinational path from op_valid back to op_ready.
  always_comb begin
    state_next = state;
    mac_clear  = 1'b0;
    op_ready   = 1'b0;
    res_valid  = 1'b0;
    busy       = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (start) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        mac_clear = 1'b1;
        // A zero-length job skips straight to capturing the freshly cleared MAC.
        if (remaining != '0) state_next = S_RUN;
        else                 state_next = S_CAPTURE;
      end
      S_RUN: begin
        op_ready = 1'b1;
        if (op_valid && remaining == LEN_WIDTH'(1)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // The final compute pulse is in flight; the MAC adds it at this edge.
        state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign beat = op_valid && op_ready;

  // State register plus the datapath registers. mac_compute is delayed one
  // cycle so that it lines up with the operands registered on the same beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      remaining   <= '0;
      mac_a       <= '0;
      mac_b       <= '0;
      mac_compute <= 1'b0;
      res_data    <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      mac_compute <= (state == S_RUN) && op_valid;
      done        <= (state == S_OUTPUT) && res_ready;

      if (state == S_IDLE && start) begin
        remaining <= length;
      end else if (beat) begin
        remaining <= remaining - LEN_WIDTH'(1);
      end

      if (beat) begin
        mac_a <= op_a;
        mac_b <= op_b;
      end

      if (state == S_CAPTURE) begin
        res_data <= mac_acc;
      end
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer
//   Directed self-checking bench for mac_sequencer. A behavioural MAC closes
//   the loop on mac_clear/mac_compute/mac_a/mac_b -> mac_acc. Expected dot
//   products are computed from the operand lists and queued when a job is
//   launched. A monitor pops them as results are handed off downstream.

module tb_mac_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] length;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        op_valid;
  logic        op_ready;
  logic        mac_clear;
  logic        mac_compute;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic [31:0] mac_acc;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        done;

  int checkCount  = 0;
  int passCount   = 0;
  int cycle       = 0;
  int clearCount  = 0;
  int readyCount  = 0;
  int doneCount   = 0;
  int resultCount = 0;
  int lastBeatCycle = 0;
  int startCycle    = 0;

  int beatA[$];
  int beatB[$];
  logic [31:0] expQueue[$];

  logic signed [31:0] accModel = '0;

  mac_sequencer #(
    .DATA_WIDTH(8),
    .ACC_WIDTH (32),
    .LEN_WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .length     (length),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .mac_clear  (mac_clear),
    .mac_compute(mac_compute),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_acc    (mac_acc),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy),
    .done       (done)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index; read #1 after a rising edge it names the cycle just begun.
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural MAC. It deliberately ignores rst so stale partial sums survive
  // a sequencer reset, and only mac_clear can zero them.
  always @(posedge clk) begin
    if (mac_clear)
      accModel <= '0;
    else if (mac_compute)
      accModel <= accModel + 32'($signed(mac_a)) * 32'($signed(mac_b));
  end
  assign mac_acc = accModel;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Mid-cycle monitor: counts control pulses, enforces clear/compute exclusion
  // and pops the scoreboard on every completed result handshake.
  always @(negedge clk) begin
    if (mac_clear) clearCount++;
    if (op_ready)  readyCount++;
    if (done)      doneCount++;
    checkOutput("clear_compute_exclusive", 32'(mac_clear && mac_compute), 32'd0);
    if (res_valid && res_ready) begin
      resultCount++;
      if (expQueue.size() == 0)
        checkOutput("unexpected_result", 32'd1, 32'd0);
      else
        checkOutput("result", res_data, expQueue.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_mac_clear",   32'(mac_clear),   32'd0);
    checkOutput("rst_mac_compute", 32'(mac_compute), 32'd0);
    checkOutput("rst_mac_a",       32'(mac_a),       32'd0);
    checkOutput("rst_mac_b",       32'(mac_b),       32'd0);
    checkOutput("rst_res_data",    res_data,         32'd0);
    checkOutput("rst_res_valid",   32'(res_valid),   32'd0);
    checkOutput("rst_done",        32'(done),        32'd0);
    checkOutput("rst_busy",        32'(busy),        32'd0);
    checkOutput("rst_op_ready",    32'(op_ready),    32'd0);
  endtask

  // Launch a job of length len and stream the pairs in beatA/beatB. With
  // bubbles set, op_valid alternates 1,0,1,0 across RUN cycles. Returns in
  // the cycle after the last accepted beat.
  task automatic applyStimulus(input int len, input bit bubbles, input bit pushExpect);
    int   sum    = 0;
    int   idx    = 0;
    int   budget = 200;
    bit   toggle = 1'b0;
    bit   accepted;
    logic [7:0] expA;
    logic [7:0] expB;
    for (int i = 0; i < beatA.size(); i++) sum += beatA[i] * beatB[i];
    if (pushExpect) expQueue.push_back(32'(sum));
    startCycle = cycle;
    start  = 1'b1;
    length = 16'(len);
    tick();
    start = 1'b0;
    checkOutput("clear_pulse", 32'(mac_clear), 32'd1);
    checkOutput("busy_in_job", 32'(busy), 32'd1);
    while (idx < beatA.size() && budget > 0) begin
      op_a     = 8'(beatA[idx]);
      op_b     = 8'(beatB[idx]);
      op_valid = bubbles ? !toggle : 1'b1;
      accepted = op_valid && op_ready;
      if (op_ready) toggle = !toggle;
      tick();
      budget--;
      checkOutput("mac_compute_follows_beat", 32'(mac_compute), 32'(accepted));
      if (accepted) begin
        expA = 8'(beatA[idx]);
        expB = 8'(beatB[idx]);
        checkOutput("mac_a_latched", 32'(mac_a), 32'(expA));
        checkOutput("mac_b_latched", 32'(mac_b), 32'(expB));
        lastBeatCycle = cycle - 1;
        idx++;
      end
    end
    if (idx < beatA.size()) checkOutput("beat_budget", 32'(idx), 32'(beatA.size()));
    op_valid = 1'b0;
  endtask

  task automatic waitValid(input int expectCycle);
    int budget = 20;
    while (!res_valid && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput("res_valid_seen", 32'(res_valid), 32'd1);
    checkOutput("res_valid_latency", 32'(cycle), 32'(expectCycle));
  endtask

  // Called in an OUTPUT cycle with res_ready already high.
  task automatic finishHandshake();
    checkOutput("done_low_before", 32'(done), 32'd0);
    tick();
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("res_valid_dropped", 32'(res_valid), 32'd0);
    tick();
    checkOutput("done_one_cycle", 32'(done), 32'd0);
  endtask

  // Directed sequence of all scenarios.
  initial begin
    int clr0;
    int rdy0;
    int done0;
    int res0;
    int fed;
    int budget;
    bit accepted;

    rst       = 1'b1;
    start     = 1'b0;
    length    = '0;
    op_a      = '0;
    op_b      = '0;
    op_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    tick();
    checkResetValues();
    rst = 1'b0;
    tick();

    // Basic K=3 job, expected -21.
    $display("[TB] basic job");
    beatA = '{2, -4, 7};
    beatB = '{3, 5, -1};
    done0 = doneCount;
    applyStimulus(3, 1'b0, 1'b1);
    waitValid(lastBeatCycle + 3);
    finishHandshake();
    checkOutput("basic_done_once", 32'(doneCount - done0), 32'd1);

    // Upstream bubbles, expected 65536 with seven RUN cycles.
    $display("[TB] upstream bubbles");
    beatA = '{-128, -128, -128, -128};
    beatB = '{-128, -128, -128, -128};
    rdy0 = readyCount;
    applyStimulus(4, 1'b1, 1'b1);
    checkOutput("drain_op_ready", 32'(op_ready), 32'd0);
    checkOutput("drain_compute", 32'(mac_compute), 32'd1);
    waitValid(lastBeatCycle + 3);
    finishHandshake();
    checkOutput("bubble_ready_cycles", 32'(readyCount - rdy0), 32'd7);

    // Zero length; the previous nonzero accumulator must not leak.
    $display("[TB] zero length");
    beatA.delete();
    beatB.delete();
    clr0 = clearCount;
    rdy0 = readyCount;
    applyStimulus(0, 1'b0, 1'b1);
    waitValid(startCycle + 3);
    finishHandshake();
    checkOutput("zero_clear_count", 32'(clearCount - clr0), 32'd1);
    checkOutput("zero_no_ready", 32'(readyCount - rdy0), 32'd0);

    // Back-pressure with start attempted during OUTPUT.
    $display("[TB] back-pressure");
    res_ready = 1'b0;
    beatA = '{10, 1};
    beatB = '{10, -1};
    done0 = doneCount;
    applyStimulus(2, 1'b0, 1'b1);
    waitValid(lastBeatCycle + 3);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_res_valid", 32'(res_valid), 32'd1);
      checkOutput("bp_res_data", res_data, 32'd99);
      checkOutput("bp_no_done", 32'(done), 32'd0);
      start  = 1'b1;
      length = 16'd7;
      tick();
    end
    start     = 1'b0;
    res_ready = 1'b1;
    finishHandshake();
    checkOutput("bp_start_ignored_busy", 32'(busy), 32'd0);
    checkOutput("bp_start_ignored_clear", 32'(mac_clear), 32'd0);
    checkOutput("bp_done_once", 32'(doneCount - done0), 32'd1);

    // Reset after two beats of a K=5 job, then a fresh K=1 job.
    $display("[TB] reset mid-job");
    beatA = '{7, 7};
    beatB = '{7, 7};
    res0 = resultCount;
    applyStimulus(5, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    checkResetValues();
    rst = 1'b0;
    tick();
    checkOutput("abort_no_result", 32'(resultCount - res0), 32'd0);
    beatA = '{3};
    beatB = '{4};
    applyStimulus(1, 1'b0, 1'b1);
    waitValid(lastBeatCycle + 3);
    finishHandshake();

    // Back-to-back jobs with start held high.
    $display("[TB] back-to-back");
    expQueue.push_back(32'd30);
    expQueue.push_back(-32'sd6);
    clr0     = clearCount;
    res0     = resultCount;
    fed      = 0;
    budget   = 60;
    start    = 1'b1;
    length   = 16'd1;
    op_valid = 1'b1;
    op_a     = 8'd5;
    op_b     = 8'd6;
    while (resultCount - res0 < 2 && budget > 0) begin
      accepted = op_valid && op_ready;
      tick();
      budget--;
      if (accepted) begin
        fed++;
        if (fed == 1) begin
          op_a = 8'hFE;
          op_b = 8'd3;
        end else begin
          op_valid = 1'b0;
        end
      end
    end
    start    = 1'b0;
    op_valid = 1'b0;
    checkOutput("b2b_results", 32'(resultCount - res0), 32'd2);
    checkOutput("b2b_clears", 32'(clearCount - clr0), 32'd2);
    tick();
    checkOutput("b2b_idle_after", 32'(busy), 32'd0);

    checkOutput("scoreboard_empty", 32'(expQueue.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
